// File: rtl/i2c_cfg_pkg.sv
// Shared types and default constants for the camera I2C configuration scheduler.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {SETTLE, FETCH, ISSUE, WAIT, GAP, RUN} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_ZOOM, SRC_EXP} src_t;

  localparam int unsigned DEF_LUT_SIZE      = 25;
  localparam logic [7:0]  DEF_SLAVE_ADDR    = 8'hBA;
  localparam logic [15:0] DEF_SETTLE_CYC    = 16'd50000;
  localparam logic [7:0]  DEF_EXP_REG       = 8'h09;
  localparam logic [15:0] DEF_INIT_EXPOSURE = 16'h0500;
  localparam logic [15:0] DEF_EXP_STEP      = 16'h0100;
  localparam logic [7:0]  DEF_ZOOM_REG      = 8'h22;
  localparam logic [15:0] DEF_ZOOM_ON_VAL   = 16'h0000;
  localparam logic [15:0] DEF_ZOOM_OFF_VAL  = 16'h0033;
  localparam logic [1:0]  DEF_MAX_RETRY     = 2'd3;

  // Unsigned step that clamps at 0 on decrease and at all-ones on increase.
  function automatic logic [15:0] sat_step(input logic [15:0] v, input logic [15:0] step,
                                           input logic dec);
    logic [16:0] sum;
    if (dec) return (v >= step) ? v - step : '0;
    sum = {1'b0, v} + {1'b0, step};
    return sum[16] ? '1 : sum[15:0];
  endfunction

endpackage

// File: rtl/i2c_cfg_scheduler_if.sv
// Request/response port between the scheduler and the I2C byte-level write master.
interface i2c_cfg_scheduler_if;
  logic [31:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_nack;

  modport master (output i2c_data, i2c_go, input i2c_end, i2c_nack);
  modport slave  (input i2c_data, i2c_go, output i2c_end, i2c_nack);
endinterface

// File: rtl/cfg_input_cond.sv
// 2-FF synchronizers for the switch/key inputs plus change and rising-edge detection.
module cfg_input_cond (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_zoom_sw,
  input  logic i_exp_adj,
  input  logic i_exp_dec,
  output logic o_zoom_evt,
  output logic o_exp_evt,
  output logic o_exp_dec,
  output logic o_zoom_lvl
);

  // Bits [1:0] are the synchronizer, bit [2] the previous synced value.
  logic [2:0] r_zoom_sync;
  logic [2:0] r_adj_sync;
  logic [1:0] r_dec_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zoom_sync <= '0;
      r_adj_sync  <= '0;
      r_dec_sync  <= '0;
    end else begin
      r_zoom_sync <= {r_zoom_sync[1:0], i_zoom_sw};
      r_adj_sync  <= {r_adj_sync[1:0], i_exp_adj};
      r_dec_sync  <= {r_dec_sync[0], i_exp_dec};
    end
  end

  assign o_zoom_evt = r_zoom_sync[2] ^ r_zoom_sync[1];
  assign o_exp_evt  = r_adj_sync[1] & ~r_adj_sync[2];
  assign o_exp_dec  = r_dec_sync[1];
  assign o_zoom_lvl = r_zoom_sync[1];

endmodule

// File: rtl/i2c_cfg_scheduler.sv
// Walks the sensor power-up table, then turns zoom/exposure events into 32-bit I2C writes.
module i2c_cfg_scheduler
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned LUT_SIZE      = DEF_LUT_SIZE,
  parameter logic [7:0]  SLAVE_ADDR    = DEF_SLAVE_ADDR,
  parameter logic [15:0] SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter logic [7:0]  EXP_REG       = DEF_EXP_REG,
  parameter logic [15:0] INIT_EXPOSURE = DEF_INIT_EXPOSURE,
  parameter logic [15:0] EXP_STEP      = DEF_EXP_STEP,
  parameter logic [7:0]  ZOOM_REG      = DEF_ZOOM_REG,
  parameter logic [15:0] ZOOM_ON_VAL   = DEF_ZOOM_ON_VAL,
  parameter logic [15:0] ZOOM_OFF_VAL  = DEF_ZOOM_OFF_VAL,
  parameter logic [1:0]  MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iZOOM_MODE_SW,
  input  logic                       iEXPOSURE_ADJ,
  input  logic                       iEXPOSURE_DEC_p,
  output logic [4:0]                 oLUT_INDEX,
  input  logic [23:0]                iLUT_DATA,
  i2c_cfg_scheduler_if.master        i2c_bus,
  output logic [15:0]                oEXPOSURE,
  output logic                       oCFG_DONE,
  output logic                       oBUSY,
  output logic                       oERR
);

  localparam logic [4:0] LAST_IDX = 5'(LUT_SIZE - 1);

  logic w_zoom_evt, w_exp_evt, w_exp_dec, w_zoom_lvl;

  cfg_input_cond u_cond (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .i_zoom_sw  (iZOOM_MODE_SW),
    .i_exp_adj  (iEXPOSURE_ADJ),
    .i_exp_dec  (iEXPOSURE_DEC_p),
    .o_zoom_evt (w_zoom_evt),
    .o_exp_evt  (w_exp_evt),
    .o_exp_dec  (w_exp_dec),
    .o_zoom_lvl (w_zoom_lvl)
  );

  state_t      r_state;
  src_t        r_src;
  logic [15:0] r_settle;
  logic [1:0]  r_retry;
  logic [4:0]  r_idx;
  logic [31:0] r_data;
  logic        r_go, r_cfg_done, r_busy, r_err;
  logic [15:0] r_exp;
  logic        r_zoom_pend, r_exp_pend;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= SETTLE;
      r_src       <= SRC_INIT;
      r_settle    <= '0;
      r_retry     <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_go        <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_busy      <= 1'b1;
      r_err       <= 1'b0;
      r_exp       <= INIT_EXPOSURE;
      r_zoom_pend <= 1'b0;
      r_exp_pend  <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: begin
          if (r_settle == SETTLE_CYC - 16'd1) r_state <= FETCH;
          else                                r_settle <= r_settle + 16'd1;
        end
        // Data and GO are registered on entry so both are visible during ISSUE.
        FETCH: begin
          r_src   <= SRC_INIT;
          r_data  <= {SLAVE_ADDR, iLUT_DATA};
          r_go    <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (i2c_bus.i2c_end) begin
            r_go <= 1'b0;
            if (i2c_bus.i2c_nack && (r_retry < MAX_RETRY)) begin
              r_retry <= r_retry + 2'd1;
              r_state <= GAP;
            end else begin
              r_retry <= '0;
              if (i2c_bus.i2c_nack) r_err <= 1'b1;
              if (r_src == SRC_INIT && r_idx != LAST_IDX) begin
                r_idx   <= r_idx + 5'd1;
                r_state <= GAP;
              end else begin
                if (r_src == SRC_INIT) r_cfg_done <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= RUN;
              end
            end
          end
        end
        GAP: begin
          if (r_retry != '0) begin
            r_go    <= 1'b1;
            r_state <= ISSUE;
          end else begin
            r_state <= FETCH;
          end
        end
        // Pending flags drop at dispatch; an event during the write re-arms them.
        RUN: begin
          if (r_zoom_pend) begin
            r_src       <= SRC_ZOOM;
            r_data      <= {SLAVE_ADDR, ZOOM_REG, w_zoom_lvl ? ZOOM_ON_VAL : ZOOM_OFF_VAL};
            r_zoom_pend <= 1'b0;
            r_go        <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end else if (r_exp_pend) begin
            r_src      <= SRC_EXP;
            r_data     <= {SLAVE_ADDR, EXP_REG, r_exp};
            r_exp_pend <= 1'b0;
            r_go       <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        default: r_state <= SETTLE;
      endcase

      if (w_zoom_evt) r_zoom_pend <= 1'b1;
      if (w_exp_evt) begin
        r_exp_pend <= 1'b1;
        r_exp      <= sat_step(r_exp, EXP_STEP, w_exp_dec);
      end
    end
  end

  assign oLUT_INDEX       = r_idx;
  assign i2c_bus.i2c_data = r_data;
  assign i2c_bus.i2c_go   = r_go;
  assign oEXPOSURE        = r_exp;
  assign oCFG_DONE        = r_cfg_done;
  assign oBUSY            = r_busy;
  assign oERR             = r_err;

endmodule

// File: tb/tb_i2c_cfg_scheduler.sv
// Directed bench for i2c_cfg_scheduler with an I2C master model and a 3-entry init ROM.
module tb_i2c_cfg_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zoom_sw, exp_adj, exp_dec;
  logic [4:0]  lut_index;
  logic [23:0] lut_data;
  logic [15:0] exposure;
  logic        cfg_done, busy, err;

  i2c_cfg_scheduler_if bus ();

  always #5 clk = ~clk;

  i2c_cfg_scheduler #(
    .LUT_SIZE   (3),
    .SETTLE_CYC (16'd10)
  ) dut (
    .iCLK            (clk),
    .iRST_N          (rst_n),
    .iZOOM_MODE_SW   (zoom_sw),
    .iEXPOSURE_ADJ   (exp_adj),
    .iEXPOSURE_DEC_p (exp_dec),
    .oLUT_INDEX      (lut_index),
    .iLUT_DATA       (lut_data),
    .i2c_bus         (bus),
    .oEXPOSURE       (exposure),
    .oCFG_DONE       (cfg_done),
    .oBUSY           (busy),
    .oERR            (err)
  );

  logic [23:0] lut [0:2] = '{24'h01_0011, 24'h20_0104, 24'h22_0033};
  always @(posedge clk) lut_data <= lut[lut_index];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // I2C master model: latches each GO, answers after m_delay cycles, logs data and GO-low gap.
  int          m_delay = 5;
  int          nack_left = 0;
  logic [31:0] nack_match = '0;
  bit          m_act = 0;
  int          m_cnt = 0;
  int          gap = 0;
  int          last_end_cyc = 0;
  logic [31:0] tx_log[$];
  int          gap_log[$];

  always @(negedge clk) begin
    bus.i2c_end  = 1'b0;
    bus.i2c_nack = 1'b0;
    if (!rst_n) begin
      m_act = 0;
      m_cnt = 0;
    end else if (!m_act) begin
      if (bus.i2c_go) begin
        m_act = 1;
        m_cnt = 0;
        tx_log.push_back(bus.i2c_data);
        gap_log.push_back(gap);
        gap = 0;
      end else begin
        gap++;
      end
    end else begin
      m_cnt++;
      if (m_cnt == m_delay) begin
        bus.i2c_end  = 1'b1;
        last_end_cyc = cyc;
        if (nack_left > 0 && bus.i2c_data == nack_match) begin
          bus.i2c_nack = 1'b1;
          nack_left--;
        end
      end else if (m_cnt > m_delay && !bus.i2c_go) begin
        m_act = 0;
        gap   = 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_exp(input logic dec);
    exp_dec = dec;
    cycles(4);
    exp_adj = 1'b1;
    cycles(3);
    exp_adj = 1'b0;
    cycles(13);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!cfg_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'b0, cfg_done}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    int run = 0;
    while (run < 8 && t < 3000) begin
      @(negedge clk);
      t++;
      if (!busy && !bus.i2c_go) run++;
      else                      run = 0;
    end
    check(tag, (run >= 8) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          n0;
    int          done_cyc;
    int          t;
    logic [31:0] exp5 [0:5];

    zoom_sw = 1'b0;
    exp_adj = 1'b0;
    exp_dec = 1'b0;
    rst_n   = 1'b0;
    cycles(3);

    check("rst_index",    {27'b0, lut_index}, 32'd0);
    check("rst_data",     bus.i2c_data, 32'd0);
    check("rst_go",       {31'b0, bus.i2c_go}, 32'd0);
    check("rst_cfg_done", {31'b0, cfg_done}, 32'd0);
    check("rst_busy",     {31'b0, busy}, 32'd1);
    check("rst_err",      {31'b0, err}, 32'd0);
    check("rst_exposure", {16'b0, exposure}, 32'h0500);

    // 1: power-up table walk
    rst_n = 1'b1;
    wait_done("t1_done");
    done_cyc = cyc;
    check("t1_ntx", tx_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_tx%0d", i), tx_at(i), {8'hBA, lut[i]});
    check("t1_done_latency", done_cyc - last_end_cyc, 32'd1);
    cycles(1);
    check("t1_busy", {31'b0, busy}, 32'd0);

    // 2: three increments coalesced behind a slow master
    m_delay = 100;
    n0 = tx_log.size();
    repeat (3) press_exp(1'b0);
    wait_idle("t2_idle");
    check("t2_exposure", {16'b0, exposure}, 32'h0800);
    check("t2_ntx", tx_log.size() - n0, 32'd2);
    check("t2_last", tx_at(tx_log.size() - 1), 32'hBA09_0800);

    // 3: decrement down to 0100, then saturate at 0000
    m_delay = 5;
    repeat (7) press_exp(1'b1);
    wait_idle("t3_idle_a");
    check("t3_exposure_0100", {16'b0, exposure}, 32'h0100);
    for (int i = 0; i < 3; i++) begin
      press_exp(1'b1);
      check($sformatf("t3_sat%0d", i), {16'b0, exposure}, 32'h0000);
    end
    wait_idle("t3_idle_b");
    check("t3_last", tx_at(tx_log.size() - 1), 32'hBA09_0000);

    // 4: zoom toggle and exposure key in the same cycle
    exp_dec = 1'b0;
    cycles(4);
    n0 = tx_log.size();
    zoom_sw = 1'b1;
    exp_adj = 1'b1;
    cycles(3);
    exp_adj = 1'b0;
    wait_idle("t4_idle");
    check("t4_ntx", tx_log.size() - n0, 32'd2);
    check("t4_zoom", tx_at(n0), 32'hBA22_0000);
    check("t4_exp", tx_at(n0 + 1), 32'hBA09_0100);
    check("t4_gap", (n0 + 1 < gap_log.size()) ? gap_log[n0 + 1] : -1, 32'd1);
    check("t4_exposure", {16'b0, exposure}, 32'h0100);

    // 5: four NACKs on entry 1 -> four identical issues, error flagged, init carries on
    zoom_sw = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    cycles(3);
    nack_match = {8'hBA, lut[1]};
    nack_left  = 4;
    n0 = tx_log.size();
    rst_n = 1'b1;
    wait_done("t5_done");
    exp5[0] = {8'hBA, lut[0]};
    for (int i = 1; i < 5; i++) exp5[i] = {8'hBA, lut[1]};
    exp5[5] = {8'hBA, lut[2]};
    check("t5_ntx", tx_log.size() - n0, 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("t5_tx%0d", i), tx_at(n0 + i), exp5[i]);
    check("t5_retry_gap", (n0 + 2 < gap_log.size()) ? gap_log[n0 + 2] : -1, 32'd1);
    check("t5_err", {31'b0, err}, 32'd1);

    // 6: asynchronous reset while a write is outstanding
    rst_n = 1'b0;
    cycles(2);
    check("t6_err_cleared", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    press_exp(1'b0);
    check("t6_exposure_pre", {16'b0, exposure}, 32'h0600);
    t = 0;
    while (!bus.i2c_go && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t6_go_seen", {31'b0, bus.i2c_go}, 32'd1);
    cycles(2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_go", {31'b0, bus.i2c_go}, 32'd0);
    check("t6_async_busy", {31'b0, busy}, 32'd1);
    check("t6_async_exposure", {16'b0, exposure}, 32'h0500);
    cycles(2);
    rst_n = 1'b1;
    n0 = tx_log.size();
    cycles(5);
    check("t6_settle_index", {27'b0, lut_index}, 32'd0);
    check("t6_settle_go", {31'b0, bus.i2c_go}, 32'd0);
    wait_done("t6_done");
    check("t6_first_tx", tx_at(n0), {8'hBA, lut[0]});
    check("t6_exposure", {16'b0, exposure}, 32'h0500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
